ifm_window_streamer: RTL and testbench

IFM_WINDOW_STREAMER -- requirements
Module: ifm_window_streamer

---
 rtl/lenet_params_pkg.sv | 17 +
 rtl/raster_position_counter.sv | 56 +++++
 rtl/ifm_window_streamer.sv | 97 +++++++++
 tb/tb_ifm_window_streamer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lenet_params_pkg.sv
// Shared LeNet streaming parameters and the window-streamer FSM encoding.
package lenet_params_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int IFM_SIZE      = 14;
  localparam int KERNAL_SIZE   = 5;
  localparam int FIFO_SIZE     = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE;
  localparam int IFM_SIZE_NEXT = IFM_SIZE - KERNAL_SIZE + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } stream_state_t;

endpackage

// File: rtl/raster_position_counter.sv
// Push-side raster bookkeeping: tracks (row,col) of the next pushed pixel and
// flags/numbers every push that completes an in-bounds KxK window.
module raster_position_counter #(
  parameter int IFM_SIZE     = 14,
  parameter int KERNAL_SIZE  = 5,
  parameter int WIN_IDX_BITS = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_push,
  output logic                    o_window_valid,
  output logic [WIN_IDX_BITS-1:0] o_window_index
);

  localparam int CW   = $clog2(IFM_SIZE);
  localparam int RW   = $clog2(IFM_SIZE + 1);
  localparam int NEXT = IFM_SIZE - KERNAL_SIZE + 1;

  localparam logic [CW-1:0]           COL_LAST = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0]           COL_MIN  = CW'(KERNAL_SIZE - 1);
  localparam logic [RW-1:0]           ROW_MIN  = RW'(KERNAL_SIZE - 1);
  localparam logic [RW-1:0]           ROW_END  = RW'(IFM_SIZE);
  localparam logic [WIN_IDX_BITS-1:0] IDX_LAST = WIN_IDX_BITS'(NEXT * NEXT - 1);

  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic                    r_valid;
  logic [WIN_IDX_BITS-1:0] r_index;

  // Validity comes from the counters alone; the first valid window needs a
  // full FIFO refill, so stale contents from a previous frame never qualify.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
    end else begin
      r_valid <= i_push && (r_row >= ROW_MIN) && (r_col >= COL_MIN);
      if (i_push) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_row != ROW_END) r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (r_valid && (r_index != IDX_LAST)) r_index <= r_index + 1'b1;
    end
  end

  assign o_window_valid = r_valid;
  assign o_window_index = r_index;

endmodule

// File: rtl/ifm_window_streamer.sv
// Streams one IFM in raster order from memory into the KxK window FIFO and
// reports when the FIFO taps hold a complete window.
module ifm_window_streamer #(
  parameter  int DATA_WIDTH       = lenet_params_pkg::DATA_WIDTH,
  parameter  int IFM_SIZE         = lenet_params_pkg::IFM_SIZE,
  parameter  int KERNAL_SIZE      = lenet_params_pkg::KERNAL_SIZE,
  localparam int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  localparam int IFM_SIZE_NEXT    = IFM_SIZE - KERNAL_SIZE + 1,
  localparam int WIN_IDX_BITS     = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        hold,
  output logic                        ifm_read_en,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address,
  input  logic [DATA_WIDTH-1:0]       ifm_data_in,
  output logic                        fifo_enable,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  output logic                        window_valid,
  output logic [WIN_IDX_BITS-1:0]     window_index,
  output logic                        busy,
  output logic                        done
);

  import lenet_params_pkg::*;

  localparam logic [ADDRESS_SIZE_IFM-1:0] ADDR_LAST =
    ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);

  stream_state_t               r_state;
  stream_state_t               w_next;
  logic [ADDRESS_SIZE_IFM-1:0] r_addr;
  logic                        r_fifo_en;
  logic                        w_start_acc;
  logic                        w_read;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_read      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next      = S_STREAM;
          w_start_acc = 1'b1;
        end
      end
      S_STREAM: begin
        w_read = !hold;
        if (!hold && (r_addr == ADDR_LAST)) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address parks on the last pixel after the frame; a new start rewinds it.
  always_ff @(posedge clk) begin
    if (reset || w_start_acc)                  r_addr <= '0;
    else if (w_read && (r_addr != ADDR_LAST))  r_addr <= r_addr + 1'b1;
  end

  // Memory data lands one cycle after the strobe; this register turns that
  // into the push, and reset kills an in-flight one.
  always_ff @(posedge clk) begin
    if (reset) r_fifo_en <= 1'b0;
    else       r_fifo_en <= w_read;
  end

  raster_position_counter #(
    .IFM_SIZE    (IFM_SIZE),
    .KERNAL_SIZE (KERNAL_SIZE),
    .WIN_IDX_BITS(WIN_IDX_BITS)
  ) u_pos (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_start_acc),
    .i_push        (r_fifo_en),
    .o_window_valid(window_valid),
    .o_window_index(window_index)
  );

  assign ifm_read_en  = w_read;
  assign ifm_address  = r_addr;
  assign fifo_enable  = r_fifo_en;
  assign fifo_data_in = ifm_data_in;
  assign busy         = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_ifm_window_streamer.sv
// Randomized frame-level bench for ifm_window_streamer with a cycle-indexed
// reference model and a golden window-FIFO tap check.
module tb_ifm_window_streamer;

  localparam int N = 14, K = 5, NX = 10, NPIX = 196, MAXC = 300;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, hold = 1'b0;
  logic        ifm_read_en, fifo_enable, window_valid, busy, done;
  logic [7:0]  ifm_address;
  logic [31:0] ifm_data_in = '0, fifo_data_in;
  logic [6:0]  window_index;

  ifm_window_streamer dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .ifm_read_en(ifm_read_en), .ifm_address(ifm_address), .ifm_data_in(ifm_data_in),
    .fifo_enable(fifo_enable), .fifo_data_in(fifo_data_in),
    .window_valid(window_valid), .window_index(window_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NPIX];
  always @(posedge clk) if (ifm_read_en) ifm_data_in <= mem[ifm_address];

  int n_cmp = 0, n_bad = 0;
  bit hold_map [MAXC];

  logic o_re [MAXC], o_fe [MAXC], o_wv [MAXC], o_busy [MAXC], o_done [MAXC];
  int   o_addr [MAXC], o_wi [MAXC];
  logic [31:0] o_fd [MAXC];
  bit   e_re [MAXC], e_fe [MAXC], e_wv [MAXC], e_busy [MAXC], e_done [MAXC];
  int   e_addr [MAXC], e_wi [MAXC];
  logic [31:0] e_fd [MAXC];

  int m_nreads, m_npush, m_first_push, m_last_push, m_first_v, m_last_v, m_nvalid;
  int m_ndone, m_done_cyc, m_tap_err;

  // Drive one frame (start at cycle 0) and record every output per cycle.
  task automatic run_frame(input int rst_at, input int xs1, input int xs2);
    logic [31:0] q[$];
    q.delete();
    foreach (mem[i]) mem[i] = $urandom;
    m_nreads = 0; m_npush = 0; m_first_push = -1; m_last_push = -1;
    m_first_v = -1; m_last_v = -1; m_nvalid = 0; m_ndone = 0; m_done_cyc = -1; m_tap_err = 0;
    for (int c = 0; c < MAXC; c++) begin
      int wr, wc, back;
      start = (c == 0) || (c == xs1) || (c == xs2);
      hold  = hold_map[c];
      reset = (c == rst_at);
      @(negedge clk);
      o_re[c] = ifm_read_en; o_addr[c] = int'(ifm_address); o_fe[c] = fifo_enable;
      o_fd[c] = fifo_data_in; o_wv[c] = window_valid; o_wi[c] = int'(window_index);
      o_busy[c] = busy; o_done[c] = done;
      if (ifm_read_en) m_nreads++;
      if (done) begin m_ndone++; m_done_cyc = c; end
      if (window_valid) begin
        if (m_first_v < 0) m_first_v = c;
        m_last_v = c; m_nvalid++;
        wr = int'(window_index) / NX; wc = int'(window_index) % NX;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) begin
            back = (K - 1 - i) * N + (K - 1 - j);
            if (q.size() <= back || (wr + i) >= N || (wc + j) >= N) m_tap_err++;
            else if (q[q.size() - 1 - back] !== mem[(wr + i) * N + wc + j]) m_tap_err++;
          end
      end
      if (fifo_enable) begin
        q.push_back(fifo_data_in);
        if (m_first_push < 0) m_first_push = c;
        m_last_push = c; m_npush++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; hold = 1'b0; reset = 1'b0;
  endtask

  // Reference: pixels read in order on every un-held streaming cycle, pushed a
  // cycle later, window flagged a cycle after its bottom-right pixel lands.
  task automatic build_model(input int rst_at);
    int k = 0, last = -1, nv = 0;
    for (int c = 0; c < MAXC; c++) begin
      e_re[c] = 0; e_fe[c] = 0; e_wv[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_addr[c] = 0; e_wi[c] = 0; e_fd[c] = '0;
    end
    for (int c = 1; c < MAXC; c++) begin
      if (k < NPIX) begin
        e_busy[c] = 1;
        if (!hold_map[c]) begin
          e_re[c] = 1; e_addr[c] = k;
          if (c + 1 < MAXC) begin e_fe[c+1] = 1; e_fd[c+1] = mem[k]; end
          if ((k / N) >= K - 1 && (k % N) >= K - 1 && c + 2 < MAXC) begin
            e_wv[c+2] = 1; e_wi[c+2] = nv; nv++;
          end
          k++;
          if (k == NPIX) last = c;
        end
      end else if (c == last + 1) e_busy[c] = 1;
      else if (c == last + 2) e_done[c] = 1;
    end
    if (rst_at >= 0)
      for (int c = rst_at + 1; c < MAXC; c++) begin
        e_re[c] = 0; e_fe[c] = 0; e_wv[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      end
  endtask

  function automatic int count_diffs();
    int d = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (o_re[c] !== e_re[c] || o_fe[c] !== e_fe[c] || o_wv[c] !== e_wv[c] ||
          o_busy[c] !== e_busy[c] || o_done[c] !== e_done[c]) d++;
      if (e_re[c] && o_addr[c] !== e_addr[c]) d++;
      if (e_fe[c] && o_fd[c] !== e_fd[c]) d++;
      if (e_wv[c] && o_wi[c] !== e_wi[c]) d++;
    end
    return d;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({ifm_read_en, fifo_enable, window_valid, busy, done} !== 5'b0) begin n_bad++; $display("FAIL reset_strobes got %b want 00000", {ifm_read_en, fifo_enable, window_valid, busy, done}); end
    n_cmp++; if (ifm_address !== 8'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", ifm_address); end
    n_cmp++; if (window_index !== 7'd0) begin n_bad++; $display("FAIL reset_index got %0d want 0", window_index); end
    @(posedge clk); #1; reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_over_start busy got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    int runs = 0;
    foreach (hold_map[i]) hold_map[i] = 0;
    run_frame(-1, -1, -1); build_model(-1);
    n_cmp++; if (count_diffs() !== 0) begin n_bad++; $display("FAIL frame_model_diffs got %0d want 0", count_diffs()); end
    n_cmp++; if (m_nreads !== NPIX) begin n_bad++; $display("FAIL frame_reads got %0d want %0d", m_nreads, NPIX); end
    n_cmp++; if (!(o_re[1] === 1'b1 && o_addr[1] == 0 && o_re[196] === 1'b1 && o_addr[196] == 195)) begin n_bad++; $display("FAIL frame_read_span got c1=%b/%0d c196=%b/%0d want 1/0 1/195", o_re[1], o_addr[1], o_re[196], o_addr[196]); end
    n_cmp++; if (m_first_push !== 2 || m_last_push !== 197) begin n_bad++; $display("FAIL frame_push_span got %0d..%0d want 2..197", m_first_push, m_last_push); end
    n_cmp++; if (m_first_v !== 63 || o_wi[63] !== 0) begin n_bad++; $display("FAIL frame_first_valid got c%0d idx %0d want c63 idx 0", m_first_v, o_wi[63]); end
    n_cmp++; if (m_nvalid !== 100 || m_last_v !== 198 || o_wi[198] !== 99) begin n_bad++; $display("FAIL frame_last_valid got n%0d c%0d idx %0d want n100 c198 idx 99", m_nvalid, m_last_v, o_wi[198]); end
    n_cmp++; if (m_done_cyc !== 198 || m_ndone !== 1) begin n_bad++; $display("FAIL frame_done got c%0d x%0d want c198 x1", m_done_cyc, m_ndone); end
    for (int c = 1; c < MAXC; c++) if (o_wv[c] === 1'b1 && o_wv[c-1] !== 1'b1) runs++;
    n_cmp++; if (runs !== NX) begin n_bad++; $display("FAIL frame_valid_runs got %0d want %0d", runs, NX); end
    n_cmp++; if (m_tap_err !== 0) begin n_bad++; $display("FAIL frame_taps got %0d bad taps want 0", m_tap_err); end
  endtask

  task automatic test_hold();
    int bad_hold = 0;
    foreach (hold_map[i]) hold_map[i] = (i >= 20 && i <= 29);
    run_frame(-1, -1, -1); build_model(-1);
    for (int c = 20; c <= 29; c++) if (o_re[c] !== 1'b0 || o_addr[c] != 19) bad_hold++;
    n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL hold_frozen got %0d bad cycles want 0", bad_hold); end
    n_cmp++; if (m_nreads !== NPIX) begin n_bad++; $display("FAIL hold_reads got %0d want %0d", m_nreads, NPIX); end
    n_cmp++; if (m_done_cyc !== 208) begin n_bad++; $display("FAIL hold_done got c%0d want c208", m_done_cyc); end
    n_cmp++; if (count_diffs() !== 0 || m_tap_err !== 0) begin n_bad++; $display("FAIL hold_model got diffs %0d taps %0d want 0 0", count_diffs(), m_tap_err); end
  endtask

  task automatic test_hold_end();
    foreach (hold_map[i]) hold_map[i] = (i >= 197 && i <= 199);
    run_frame(-1, -1, -1); build_model(-1);
    n_cmp++; if (o_fe[197] !== 1'b1 || o_fd[197] !== mem[195]) begin n_bad++; $display("FAIL hold_end_push got %b/%h want 1/%h", o_fe[197], o_fd[197], mem[195]); end
    n_cmp++; if (m_done_cyc !== 198 || o_busy[197] !== 1'b1) begin n_bad++; $display("FAIL hold_end_done got c%0d busy197 %b want c198 1", m_done_cyc, o_busy[197]); end
    n_cmp++; if (count_diffs() !== 0) begin n_bad++; $display("FAIL hold_end_model got diffs %0d want 0", count_diffs()); end
  endtask

  task automatic test_restart();
    foreach (hold_map[i]) hold_map[i] = 0;
    run_frame(-1, 100, 198); build_model(-1);
    n_cmp++; if (count_diffs() !== 0 || m_ndone !== 1) begin n_bad++; $display("FAIL restart_ignored got diffs %0d dones %0d want 0 1", count_diffs(), m_ndone); end
    n_cmp++; if (o_busy[199] !== 1'b0) begin n_bad++; $display("FAIL restart_done_start busy got %b want 0", o_busy[199]); end
    run_frame(-1, -1, -1); build_model(-1);
    n_cmp++; if (m_first_v !== 63 || o_wi[63] !== 0) begin n_bad++; $display("FAIL restart_first_valid got c%0d idx %0d want c63 0", m_first_v, o_wi[63]); end
    n_cmp++; if (count_diffs() !== 0 || m_tap_err !== 0 || m_done_cyc !== 198) begin n_bad++; $display("FAIL restart_frame got diffs %0d taps %0d done c%0d want 0 0 c198", count_diffs(), m_tap_err, m_done_cyc); end
  endtask

  task automatic test_reset_mid();
    int late_push = 0, late_busy = 0;
    foreach (hold_map[i]) hold_map[i] = 0;
    run_frame(120, -1, -1); build_model(120);
    for (int c = 121; c < MAXC; c++) begin
      if (o_fe[c] !== 1'b0) late_push++;
      if (o_busy[c] !== 1'b0) late_busy++;
    end
    n_cmp++; if ({o_re[121], o_fe[121], o_wv[121], o_busy[121], o_done[121]} !== 5'b0 || o_addr[121] != 0 || o_wi[121] != 0) begin n_bad++; $display("FAIL reset_mid_outputs got re%b fe%b wv%b busy%b done%b addr%0d idx%0d want all 0", o_re[121], o_fe[121], o_wv[121], o_busy[121], o_done[121], o_addr[121], o_wi[121]); end
    n_cmp++; if (late_push !== 0 || late_busy !== 0) begin n_bad++; $display("FAIL reset_mid_quiet got pushes %0d busy %0d want 0 0", late_push, late_busy); end
    n_cmp++; if (count_diffs() !== 0) begin n_bad++; $display("FAIL reset_mid_model got diffs %0d want 0", count_diffs()); end
    run_frame(-1, -1, -1); build_model(-1);
    n_cmp++; if (count_diffs() !== 0 || m_tap_err !== 0 || m_done_cyc !== 198) begin n_bad++; $display("FAIL reset_mid_clean got diffs %0d taps %0d done c%0d want 0 0 c198", count_diffs(), m_tap_err, m_done_cyc); end
  endtask

  task automatic test_random_hold();
    for (int t = 0; t < 3; t++) begin
      foreach (hold_map[i]) hold_map[i] = (i < 220) && ($urandom_range(0, 3) == 0);
      run_frame(-1, $urandom_range(5, 150), -1); build_model(-1);
      n_cmp++; if (m_nreads !== NPIX || m_nvalid !== 100 || m_ndone !== 1) begin n_bad++; $display("FAIL rand_hold_counts[%0d] got r%0d v%0d d%0d want 196 100 1", t, m_nreads, m_nvalid, m_ndone); end
      n_cmp++; if (count_diffs() !== 0 || m_tap_err !== 0) begin n_bad++; $display("FAIL rand_hold_model[%0d] got diffs %0d taps %0d want 0 0", t, count_diffs(), m_tap_err); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_hold_end();
    test_restart();
    test_reset_mid();
    test_random_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
